mux2_share_arbiter: RTL and testbench
=====================================

// Module: mux2_share_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one 2-bit, 2:1 select datapath between two requesters.
//  It grants the path to one requester at a time and drives the select line.
//  It registers the selected 2-bit word onto a shared output with a valid flag.
//  Sits between the two producer units and the downstream 2-bit consumer in the 8-bit computer datapath.
// PARAMETERS
//  MAX_HOLD  default 8  max consecutive grant cycles per ownership before forced hand-over (>=2)
//  CNT_W     default 3  hold-counter width; must satisfy 2**CNT_W >= MAX_HOLD
// PORTS
//  clk       in   1  system clock, all state updates on rising edge
//  rst_n     in   1  asynchronous, active-low reset
//  req       in   2  req[k]=1: requester k wants the shared path
//  last      in   2  last[k]=1: requester k's current word is its final one; qualified by req[k] and gnt[k]
//  data0     in   2  word from requester 0
//  data1     in   2  word from requester 1
//  gnt       out  2  one-hot grant (registered); 2'b00 when idle
//  sel       out  1  select line for the shared path: 0=data0, 1=data1 (registered)
//  data_out  out  2  registered selected word
//  out_valid out  1  data_out holds a word transferred under grant
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, gnt=00, sel=0, data_out=00, out_valid=0, hold_cnt=0.
//   - last_owner=1, so requester 0 wins the first tie.
//  States: IDLE, OWN0, OWN1. Encoding: IDLE=2'b00, OWN0=2'b01, OWN1=2'b10. gnt equals the state bits.
//  sel=1 only in OWN1; it holds its previous value in IDLE.
//  IDLE, cycle N:
//   - req=01 -> OWN0 at N+1; req=10 -> OWN1 at N+1.
//   - req=11 -> grant the requester != last_owner.
//   - req=00 -> stay in IDLE.
//   - Grant latency is 1 cycle.
//  OWNk, each cycle with req[k]=1:
//   - data_out <= data_k; out_valid <= 1 (word visible the cycle after it is sampled).
//   - hold_cnt increments.
//  OWNk, each cycle with req[k]=0: out_valid <= 0.
//  Release condition in OWNk: (req[k]&last[k]) | ~req[k] | (hold_cnt==MAX_HOLD-1).
//   - The final word under last or timeout is still transferred.
//   - On release, last_owner<=k and hold_cnt<=0.
//   - Next state: OWN(other) if req[other]=1 (no idle bubble); else OWNk if req[k]=1 and the release was timeout-only (counter restarts, no bubble); else IDLE.
//  Simultaneous last[k] and timeout: treated as one release.
//  last[k] while gnt[k]=0: ignored. req may drop at any time.
//  In IDLE, out_valid <= 0 and data_out holds its value.
//  hold_cnt never exceeds MAX_HOLD-1 and never wraps.
//  Reset mid-grant: all outputs return to reset values immediately (asynchronously). The in-flight word is discarded.
// STRUCTURE
//  Shared include arb_defs.vh holds:
//   - state encodings ST_IDLE, ST_OWN0, ST_OWN1
//   - default MAX_HOLD
//  Sub-module hold_timer(clk, rst_n, clear, en, expire), parameterised by MAX_HOLD/CNT_W.
//   - expire asserted when count==MAX_HOLD-1.
//  FSM, round-robin pointer and output register stay in the top level.
// TESTING
//  1 reset: rst_n=0 while OWN1 with out_valid=1 -> gnt=00, sel=0, data_out=00, out_valid=0 with no clock edge.
//  2 single requester: req=01 at c0, data0=2'b10, last0=1 at c3 -> gnt=01 at c1..c3; data_out=10, out_valid=1 at c2..c4; gnt=00 at c4.
//  3 tie: req=11 at c0 after reset -> gnt=01 at c1; last0 at c2 -> gnt=10, sel=1 at c3 with no IDLE cycle.
//  4 timeout: MAX_HOLD=4, req=11 held, last=00 -> gnt alternates 01,01,01,01,10,10,10,10,01...
//  5 lone timeout: MAX_HOLD=4, req=01 held 12 cycles -> gnt stays 01; out_valid stays 1 every cycle after the first.
//  6 req drop: OWN0, req0 falls at c5 without last -> out_valid=0 at c6, gnt=00 at c6; last1 pulsed in IDLE has no effect.

Source files
------------

// File: rtl/mux2_share_arbiter_pkg.sv
// Shared definitions for the two-requester shared-path arbiter: state
// encodings (which double as the one-hot grant) and the default hold limit.
package mux2_share_arbiter_pkg;

  localparam int DATA_W       = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

endpackage

// File: rtl/mux2_share_arbiter_hold_timer.sv
// Per-ownership hold counter: counts granted transfer cycles and flags the
// last cycle an owner may keep the path before a forced hand-over.
module hold_timer #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == CNT_W'(MAX_HOLD - 1));

  // Clear wins over increment; saturates at MAX_HOLD-1 so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux2_share_arbiter.sv
// Round-robin arbiter sharing one 2-bit 2:1 select path between two
// requesters; registers the granted word onto data_out with out_valid.
module mux2_share_arbiter
  import mux2_share_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        last,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic              sel,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid
);

  state_t state, state_nxt;
  logic   last_owner;
  logic   owning, own_idx, own_req, own_last, oth_req;
  logic   expire, release_own;

  assign owning   = (state == ST_OWN0) || (state == ST_OWN1);
  assign own_idx  = (state == ST_OWN1);
  assign own_req  = req[own_idx];
  assign own_last = last[own_idx];
  assign oth_req  = req[!own_idx];

  // last and timeout together still count as a single release
  assign release_own = owning && (!own_req || own_last || expire);

  hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (release_own),
    .en     (owning && own_req),
    .expire (expire)
  );

  // ---- stage: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage: next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        case (req)
          2'b01:   state_nxt = ST_OWN0;
          2'b10:   state_nxt = ST_OWN1;
          2'b11:   state_nxt = last_owner ? ST_OWN0 : ST_OWN1;
          default: state_nxt = ST_IDLE;
        endcase
      end
      ST_OWN0, ST_OWN1: begin
        if (release_own) begin
          if (oth_req) begin
            state_nxt = own_idx ? ST_OWN0 : ST_OWN1;
          end else if (own_req && !own_last) begin
            // timeout with nobody waiting: keep the grant, counter restarts
            state_nxt = state;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage: FSM outputs ----
  always_comb begin
    gnt = state;
  end

  // ---- stage: shared output register and round-robin pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= 1'b0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      out_valid <= owning && own_req;
      if (owning && own_req) begin
        data_out <= own_idx ? data1 : data0;
      end
      if (release_own) begin
        last_owner <= own_idx;
      end
      if (state_nxt == ST_OWN1) begin
        sel <= 1'b1;
      end else if (state_nxt == ST_OWN0) begin
        sel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// Scoreboard bench for mux2_share_arbiter: a transaction-level ownership
// model predicts each cycle's outputs; a monitor pops and compares them.
module tb_mux2_share_arbiter;
  import mux2_share_arbiter_pkg::*;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, last, data0, data1;
  logic [1:0] gnt, data_out;
  logic       sel, out_valid;

  always #5 clk = ~clk;

  mux2_share_arbiter #(.MAX_HOLD(MH), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .data0     (data0),
    .data1     (data1),
    .gnt       (gnt),
    .sel       (sel),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  typedef struct packed {
    logic [1:0] gnt;
    logic       sel;
    logic       valid;
    logic [1:0] held;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] word_q[$];
  int         n_total = 0;
  int         n_pass  = 0;

  // Reference model: who owns the path, how long, and who owned it last.
  int         m_owner;
  int         m_run;
  int         m_last_owner;
  logic       m_sel;
  logic [1:0] m_data;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
  endtask

  function automatic logic [1:0] gnt_of(input int owner);
    if (owner < 0) return 2'b00;
    return (owner == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_reset();
    m_owner      = -1;
    m_run        = 0;
    m_last_owner = 1;
    m_sel        = 1'b0;
    m_data       = 2'b00;
  endtask

  task automatic model_step(input logic [1:0] r, input logic [1:0] l,
                            input logic [1:0] d0, input logic [1:0] d1);
    logic valid;
    int   k;
    valid = 1'b0;
    if (m_owner < 0) begin
      if (r == 2'b01) m_owner = 0;
      else if (r == 2'b10) m_owner = 1;
      else if (r == 2'b11) m_owner = 1 - m_last_owner;
    end else begin
      k = m_owner;
      m_run++;
      if (r[k]) begin
        valid  = 1'b1;
        m_data = (k == 1) ? d1 : d0;
        word_q.push_back(m_data);
      end
      if (!r[k] || l[k] || m_run == MH) begin
        m_last_owner = k;
        m_run        = 0;
        if (r[1-k]) m_owner = 1 - k;
        else if (r[k] && !l[k]) m_owner = k;
        else m_owner = -1;
      end
    end
    if (m_owner >= 0) m_sel = (m_owner == 1);
    exp_q.push_back('{gnt: gnt_of(m_owner), sel: m_sel, valid: valid, held: m_data});
  endtask

  task automatic cyc(input logic [1:0] r, input logic [1:0] l,
                     input logic [1:0] d0, input logic [1:0] d1);
    @(posedge clk);
    #2;
    req = r; last = l; data0 = d0; data1 = d1;
    model_step(r, l, d0, d1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req = 2'b00; last = 2'b00;
    model_reset();
    exp_q.delete();
    word_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle control check, and the word queue popped whenever
  // the DUT presents a valid word.
  initial begin
    exp_t e;
    logic [1:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", 8'(gnt), 8'(e.gnt));
        check("sel", 8'(sel), 8'(e.sel));
        check("out_valid", 8'(out_valid), 8'(e.valid));
        if (!e.valid) check("data_hold", 8'(data_out), 8'(e.held));
      end
      if (rst_n && out_valid) begin
        if (word_q.size() > 0) begin
          w = word_q.pop_front();
          check("data_out", 8'(data_out), 8'(w));
        end else begin
          check("unexpected_word", 8'(out_valid), 8'd0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req = 2'b00; last = 2'b00; data0 = 2'b00; data1 = 2'b00;
    model_reset();
    #12;
    check("rst_gnt", 8'(gnt), 8'd0);
    check("rst_sel", 8'(sel), 8'd0);
    check("rst_data", 8'(data_out), 8'd0);
    check("rst_valid", 8'(out_valid), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single requester ending with last
    cyc(2'b01, 2'b00, 2'b10, 2'b00);
    cyc(2'b01, 2'b00, 2'b10, 2'b00);
    cyc(2'b01, 2'b00, 2'b10, 2'b00);
    cyc(2'b01, 2'b01, 2'b10, 2'b00);
    repeat (3) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    // tie after reset, hand-over on last without bubble
    do_reset();
    cyc(2'b11, 2'b00, 2'b01, 2'b10);
    cyc(2'b11, 2'b00, 2'b01, 2'b10);
    cyc(2'b11, 2'b01, 2'b11, 2'b10);
    repeat (3) cyc(2'b11, 2'b00, 2'b00, 2'b01);
    repeat (2) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    // timeout alternation with both requesting
    for (int i = 0; i < 20; i++)
      cyc(2'b11, 2'b00, 2'($urandom), 2'($urandom));
    repeat (2) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    // lone requester timing out keeps the grant
    for (int i = 0; i < 12; i++)
      cyc(2'b01, 2'b00, 2'($urandom), 2'b00);
    repeat (2) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    // request drop without last, then last1 pulsed while idle
    repeat (5) cyc(2'b01, 2'b00, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 2'b00, 2'b00);
    cyc(2'b00, 2'b10, 2'b00, 2'b01);
    repeat (2) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(2'($urandom), {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
          2'($urandom), 2'($urandom));
    repeat (2) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    // asynchronous reset while OWN1 holds a valid word
    cyc(2'b10, 2'b00, 2'b00, 2'b11);
    cyc(2'b10, 2'b00, 2'b00, 2'b11);
    @(posedge clk);
    #3;
    check("pre_rst_gnt", 8'(gnt), 8'd2);
    check("pre_rst_valid", 8'(out_valid), 8'd1);
    rst_n = 1'b0;
    req = 2'b00; last = 2'b00;
    model_reset();
    exp_q.delete();
    word_q.delete();
    #1;
    check("arst_gnt", 8'(gnt), 8'd0);
    check("arst_sel", 8'(sel), 8'd0);
    check("arst_data", 8'(data_out), 8'd0);
    check("arst_valid", 8'(out_valid), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first tie after reset goes to requester 0 again
    cyc(2'b11, 2'b00, 2'b01, 2'b10);
    cyc(2'b11, 2'b11, 2'b01, 2'b10);
    repeat (3) cyc(2'b00, 2'b00, 2'b00, 2'b00);

    @(posedge clk);
    #3;
    check("queue_drain", 8'(exp_q.size() + word_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
